stopwatch_tick_gen: RTL and testbench
=====================================

// Module: stopwatch_tick_gen
// PURPOSE
//  Upstream rate stage of the stopwatch: turns the board clock into a one-cycle
//  count-enable pulse (tick) for the BCD counter chain.
//  Conditions the raw SPEED_UP/SPEED_DOWN buttons: sync, debounce, rising edge.
//  Steps a saturating speed level that sets the tick period.
//  Replaces direct gating of the counter clock; everything stays on clk.
// PARAMETERS
//  CLK_HZ           50_000_000  frequency of clk
//  BASE_TICK_HZ     1           tick rate at level LEVEL_X1 (normal speed)
//  DEBOUNCE_CYCLES  1_000_000   cycles a synced button must hold a new value
// PORTS
//  clk         in   1  system clock, all logic rising-edge
//  RESET_N     in   1  asynchronous, active-low reset
//  run         in   1  1 = generate ticks; 0 = hold divider cleared
//  SPEED_UP    in   1  raw button, asynchronous, active-high
//  SPEED_DOWN  in   1  raw button, asynchronous, active-high
//  tick        out  1  one-cycle count-enable pulse
//  speed_level out  3  current level 0..4 (x1/4, x1/2, x1, x2, x4)
//  at_min      out  1  speed_level == 0
//  at_max      out  1  speed_level == 4
// BEHAVIOUR
//  Reset (RESET_N=0, async), all state cleared:
//   tick=0, speed_level=LEVEL_X1 (2), at_min=0, at_max=0.
//   Divider=0; debounce state=0 (released).
//  Divider terminal count:
//   DIV_X1 = CLK_HZ/BASE_TICK_HZ.
//   PERIOD(level) = (DIV_X1*4) >> level, giving 4x, 2x, 1x, 1/2x and 1/4x DIV_X1.
//   Elaboration error if DIV_X1 % 4 != 0 or DIV_X1 < 4.
//   Divider width = $clog2(DIV_X1*4).
//  Counting:
//   With run=1, the divider increments each cycle.
//   On the cycle it equals PERIOD-1: tick=1 (registered) and divider wraps to 0.
//   First tick comes PERIOD cycles after run rises.
//   run=0: divider forced to 0, tick=0. Deasserting mid-period discards
//   the partial count.
//  Button path (per button, identical):
//   2-FF synchronizer -> debounce counter.
//   Counter reloads to 0 whenever synced input equals the stable state.
//   Otherwise it increments; at DEBOUNCE_CYCLES-1 the stable state toggles.
//   A 0->1 change of the stable state gives a one-cycle press pulse.
//   Button-to-pulse latency is 2 + DEBOUNCE_CYCLES cycles.
//  Level update (on press pulses):
//   up only: level+1, saturates at 4. down only: level-1, saturates at 0.
//   Both pulses in the same cycle: no change.
//   Press while saturated: ignored, divider NOT restarted.
//  On any actual level change:
//   Divider restarts at 0 the next cycle and no tick is issued that cycle.
//   No stale longer period survives a speed-up.
//  Independence: presses act regardless of run. A held button yields exactly
//   one step; release then re-press is needed for the next step.
//  at_min/at_max are decoded combinationally from the speed_level register.
// STRUCTURE
//  stopwatch_pkg holds:
//   typedef logic [2:0] speed_level_t;
//   LEVEL_MIN=0, LEVEL_X1=2, LEVEL_MAX=4.
//   function period_of(level, div_x1).
//  One sub-module, button_conditioner (sync + debounce + rise pulse),
//   parameter DEBOUNCE_CYCLES, instantiated twice.
//  Level register and divider live in this module.
// TESTING
//  Bench params: CLK_HZ=64, BASE_TICK_HZ=4 (DIV_X1=16), DEBOUNCE_CYCLES=3.
//  1. Reset, run=1 -> level=2; ticks every 16 cycles, first 16 cycles after run.
//  2. Four clean UP presses -> levels 3,4,4,4; at_max=1; level-4 tick period 4.
//     Saturated presses cause no divider restart.
//  3. UP glitch of 2 cycles -> no level change. Held 10 cycles -> exactly one step.
//  4. UP and DOWN pulses coincide -> level stays 2, tick cadence unbroken.
//  5. run dropped at divider=10, then raised -> tick 16 cycles after rise.
//     Three DOWN presses -> level 0, at_min=1, period 64.
//  6. RESET_N asserted mid-period and mid-debounce -> tick=0 immediately.
//     Level=2; after release no spurious press pulse.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - speed level type, level bounds and tick period helper
package stopwatch_pkg;

  typedef logic [2:0] speed_level_t;

  localparam speed_level_t LEVEL_MIN = 3'd0;
  localparam speed_level_t LEVEL_X1  = 3'd2;
  localparam speed_level_t LEVEL_MAX = 3'd4;

  // Level 0 is the slowest (4x the base period), level 4 the fastest (1/4x).
  function automatic int unsigned period_of(speed_level_t level, int unsigned div_x1);
    return (div_x1 * 4) >> level;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - 2-FF sync, debounce and rising-edge press pulse
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= 2'b00;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Pulse only on the released-to-pressed transition of the stable state.
        cnt    <= '0;
        stable <= ~stable;
        press  <= ~stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_tick_gen.sv
// rtl/stopwatch_tick_gen.sv - count-enable tick generator with button-stepped speed level
module stopwatch_tick_gen
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned BASE_TICK_HZ    = 1,
  parameter int          DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         RESET_N,
  input  logic         run,
  input  logic         SPEED_UP,
  input  logic         SPEED_DOWN,
  output logic         tick,
  output speed_level_t speed_level,
  output logic         at_min,
  output logic         at_max
);

  localparam int unsigned DIV_X1 = CLK_HZ / BASE_TICK_HZ;
  localparam int          DIV_W  = $clog2(DIV_X1 * 4);

  generate
    if ((DIV_X1 % 4 != 0) || (DIV_X1 < 4)) begin : g_bad_div
      $error("stopwatch_tick_gen: CLK_HZ/BASE_TICK_HZ must be a multiple of 4 and at least 4");
    end
  endgenerate

  logic             up_press;
  logic             down_press;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] last_count;
  speed_level_t     next_level;
  logic             level_step;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (clk),
    .rst_n (RESET_N),
    .raw   (SPEED_UP),
    .press (up_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk   (clk),
    .rst_n (RESET_N),
    .raw   (SPEED_DOWN),
    .press (down_press)
  );

  // Coincident presses cancel; a press against a saturated level is not a step.
  always_comb begin
    next_level = speed_level;
    level_step = 1'b0;
    if (up_press && !down_press && speed_level != LEVEL_MAX) begin
      next_level = speed_level + 3'd1;
      level_step = 1'b1;
    end else if (down_press && !up_press && speed_level != LEVEL_MIN) begin
      next_level = speed_level - 3'd1;
      level_step = 1'b1;
    end
  end

  assign last_count = DIV_W'(period_of(speed_level, DIV_X1) - 1);

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      speed_level <= LEVEL_X1;
      div         <= '0;
      tick        <= 1'b0;
    end else begin
      speed_level <= next_level;
      tick        <= 1'b0;
      // Restarting on a step keeps a stale long period from delaying a speed-up.
      if (level_step || !run) begin
        div <= '0;
      end else if (div == last_count) begin
        div  <= '0;
        tick <= 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  assign at_min = (speed_level == LEVEL_MIN);
  assign at_max = (speed_level == LEVEL_MAX);

endmodule

// File: tb/tb_stopwatch_tick_gen.sv
// tb/tb_stopwatch_tick_gen.sv - directed self-checking bench for stopwatch_tick_gen
module tb_stopwatch_tick_gen;

  logic       clk        = 1'b0;
  logic       RESET_N    = 1'b0;
  logic       run        = 1'b0;
  logic       SPEED_UP   = 1'b0;
  logic       SPEED_DOWN = 1'b0;
  logic       tick;
  logic [2:0] speed_level;
  logic       at_min;
  logic       at_max;

  int checks = 0;
  int errors = 0;

  stopwatch_tick_gen #(
    .CLK_HZ          (64),
    .BASE_TICK_HZ    (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk         (clk),
    .RESET_N     (RESET_N),
    .run         (run),
    .SPEED_UP    (SPEED_UP),
    .SPEED_DOWN  (SPEED_DOWN),
    .tick        (tick),
    .speed_level (speed_level),
    .at_min      (at_min),
    .at_max      (at_max)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic edges_to_tick(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (tick) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic edges_to_level_change(input int max, output int n);
    logic [2:0] old;
    old = speed_level;
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (speed_level != old) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_ticks(input int n, output int c);
    c = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (tick) c++;
    end
  endtask

  task automatic press(input bit up, input bit down, input int hold);
    SPEED_UP   = up;
    SPEED_DOWN = down;
    step(hold);
    SPEED_UP   = 1'b0;
    SPEED_DOWN = 1'b0;
    step(8);
  endtask

  initial begin
    int n;
    int c;

    // 1: reset state and base cadence at level 2 (period 16)
    #12;
    check("rst_tick", tick, 0);
    check("rst_level", speed_level, 2);
    check("rst_at_min", at_min, 0);
    check("rst_at_max", at_max, 0);
    @(posedge clk);
    #1;
    RESET_N = 1'b1;
    run     = 1'b1;
    edges_to_tick(40, n);
    check("first_tick", n, 16);
    edges_to_tick(40, n);
    check("x1_period", n, 16);

    // 2: up presses, restart on change, saturation without restart
    SPEED_UP = 1'b1;
    edges_to_level_change(20, n);
    check("up_latency", n, 6);
    check("level_3", speed_level, 3);
    edges_to_tick(20, n);
    check("x2_after_restart", n, 8);
    SPEED_UP = 1'b0;
    step(8);
    press(1'b1, 1'b0, 6);
    check("level_4", speed_level, 4);
    check("at_max_4", at_max, 1);
    check("at_min_4", at_min, 0);
    edges_to_tick(20, n);
    edges_to_tick(20, n);
    check("x4_period", n, 4);
    SPEED_UP = 1'b1;
    c = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 6) SPEED_UP = 1'b0;
      if (tick) c++;
    end
    check("sat_no_restart", c, 10);
    check("sat_level3", speed_level, 4);
    step(8);
    press(1'b1, 1'b0, 6);
    check("sat_level4", speed_level, 4);

    // 3: glitch rejection and single step on a long hold
    press(1'b0, 1'b1, 6);
    press(1'b0, 1'b1, 6);
    check("down_to_2", speed_level, 2);
    SPEED_UP = 1'b1;
    step(2);
    SPEED_UP = 1'b0;
    step(10);
    check("glitch_ignored", speed_level, 2);
    press(1'b1, 1'b0, 10);
    check("held_one_step", speed_level, 3);
    press(1'b0, 1'b1, 6);
    check("back_to_2", speed_level, 2);

    // 4: coincident presses cancel and leave the cadence alone
    edges_to_tick(20, n);
    SPEED_UP   = 1'b1;
    SPEED_DOWN = 1'b1;
    c = 0;
    for (int i = 1; i <= 48; i++) begin
      @(posedge clk);
      #1;
      if (i == 6) begin
        SPEED_UP   = 1'b0;
        SPEED_DOWN = 1'b0;
      end
      if (tick) c++;
    end
    check("both_cadence", c, 3);
    check("both_level", speed_level, 2);

    // 5: run drop discards partial count; descend to level 0
    edges_to_tick(20, n);
    step(10);
    run = 1'b0;
    count_ticks(20, c);
    check("run_off_no_tick", c, 0);
    run = 1'b1;
    edges_to_tick(40, n);
    check("run_restart", n, 16);
    press(1'b0, 1'b1, 6);
    press(1'b0, 1'b1, 6);
    press(1'b0, 1'b1, 6);
    check("level_0", speed_level, 0);
    check("at_min_0", at_min, 1);
    check("at_max_0", at_max, 0);
    edges_to_tick(80, n);
    edges_to_tick(80, n);
    check("x1_4_period", n, 64);

    // 6: async reset mid-period and mid-debounce
    step(61);
    SPEED_UP = 1'b1;
    step(3);
    check("tick_before_reset", tick, 1);
    #1;
    RESET_N = 1'b0;
    #1;
    check("async_tick", tick, 0);
    check("async_level", speed_level, 2);
    check("async_at_min", at_min, 0);
    SPEED_UP = 1'b0;
    step(3);
    RESET_N = 1'b1;
    edges_to_tick(40, n);
    check("post_reset_tick", n, 16);
    check("no_spurious_press", speed_level, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
